enemy_shot_sched: RTL

//  Shares the single enemy-missile resource between N enemies. Each enemy's ctl_enemy

---
 rtl/enemy_shot_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/enemy_shot_sched.sv
`default_nettype none
// ============================================================================
//  Module   : enemy_shot_sched
//  Purpose  : Shares one enemy missile between N enemies. Shot requests are
//             latched per enemy, dropped if the enemy dies, and arbitrated
//             round-robin. The winner gets a one-cycle launch pulse with its
//             muzzle position; no further launch happens until the missile
//             retires and a cooldown of COOLDOWN cycles has elapsed.
//  Ports    : pclk, rst            clock / synchronous active-high reset
//             shot_req[N]          per-enemy shot request (level or pulse)
//             alive[N]             per-enemy alive flag
//             xpos_enemy/ypos_enemy packed 11-bit positions, enemy i at [11*i+:11]
//             missile_done         missile retired (left screen / hit player)
//             launch               one-cycle missile start pulse
//             grant[N]             one-hot owner of the in-flight missile
//             xpos_launch/ypos_launch registered muzzle position of last launch
//             busy                 high while LAUNCH / FLIGHT / COOL
//  Revision : 1.0  initial release
// ============================================================================
module enemy_shot_sched #(
   parameter int N        = 4,
   parameter int COOLDOWN = 20000000,
   parameter int CW       = 25,
   parameter int XOFF     = 16,
   parameter int YOFF     = 32
) (
   input  logic            pclk,
   input  logic            rst,
   input  logic [N-1:0]    shot_req,
   input  logic [N-1:0]    alive,
   input  logic [11*N-1:0] xpos_enemy,
   input  logic [11*N-1:0] ypos_enemy,
   input  logic            missile_done,
   output logic            launch,
   output logic [N-1:0]    grant,
   output logic [10:0]     xpos_launch,
   output logic [10:0]     ypos_launch,
   output logic            busy
);

   localparam int            PW          = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] c_cool_load = CW'(COOLDOWN - 1);
   localparam logic [10:0]   c_xoff      = 11'(XOFF);
   localparam logic [10:0]   c_yoff      = 11'(YOFF);
   localparam logic [PW-1:0] c_ptr_rst   = PW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_FLIGHT = 2'd2,
      S_COOL   = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [N-1:0]  r_pending;
   logic [N-1:0]  w_pend_nxt;
   logic [PW-1:0] r_ptr;
   logic [CW-1:0] r_cnt;

   logic          w_found;
   logic [PW-1:0] w_win;
   logic [N-1:0]  w_oh;
   logic [10:0]   w_x;
   logic [10:0]   w_y;

   // Round-robin scan: candidate at distance k from the last winner is
   // enemy (ptr+k) mod N; the nearest pending one wins. Only the registered
   // pending vector is scanned, so a request needs one edge to be latched.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_oh    = '0;
      w_x     = '0;
      w_y     = '0;
      for (int k = 1; k <= N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!w_found && r_pending[i] &&
                ((int'(r_ptr) + k == i) || (int'(r_ptr) + k == i + N))) begin
               w_found = 1'b1;
               w_win   = PW'(i);
               w_oh[i] = 1'b1;
               w_x     = xpos_enemy[11*i +: 11];
               w_y     = ypos_enemy[11*i +: 11];
            end
         end
      end
   end

   // Requests accumulate in every state but die with their enemy. The
   // winner's bit is cleared on the granting edge, which also swallows any
   // request it raises in that same cycle.
   always_comb begin
      w_pend_nxt = (r_pending | shot_req) & alive;
      if (r_state == S_IDLE && w_found) begin
         w_pend_nxt = w_pend_nxt & ~w_oh;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_found) w_state_nxt = S_LAUNCH;
         S_LAUNCH: w_state_nxt = S_FLIGHT;
         S_FLIGHT: if (missile_done) w_state_nxt = S_COOL;
         S_COOL:   if (r_cnt == '0) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_pending   <= '0;
         r_ptr       <= c_ptr_rst;
         r_cnt       <= '0;
         launch      <= 1'b0;
         grant       <= '0;
         xpos_launch <= '0;
         ypos_launch <= '0;
         busy        <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pend_nxt;
         // Outputs follow the next state so they line up with r_state.
         launch    <= (w_state_nxt == S_LAUNCH);
         busy      <= (w_state_nxt != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  grant       <= w_oh;
                  r_ptr       <= w_win;
                  xpos_launch <= w_x + c_xoff;
                  ypos_launch <= w_y + c_yoff;
               end
            end
            S_FLIGHT: begin
               // Grant stays with the owner even if it dies mid-flight.
               if (missile_done) begin
                  grant <= '0;
                  r_cnt <= c_cool_load;
               end
            end
            S_COOL: begin
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
